// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the execute-stage blocks.
//   muldiv_op_e : RV32M funct3 encodings
//   ALU_*       : one-hot function selects for the alu
//   md_*        : operand-signedness helpers for the multiply/divide sequencer
package riscv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_e;

    localparam logic [10:0] ALU_ADD  = 11'h001;
    localparam logic [10:0] ALU_SLL  = 11'h002;
    localparam logic [10:0] ALU_SLT  = 11'h004;
    localparam logic [10:0] ALU_SLTU = 11'h008;
    localparam logic [10:0] ALU_XOR  = 11'h010;
    localparam logic [10:0] ALU_SRL  = 11'h020;
    localparam logic [10:0] ALU_OR   = 11'h040;
    localparam logic [10:0] ALU_AND  = 11'h080;
    localparam logic [10:0] ALU_SUB  = 11'h100;
    localparam logic [10:0] ALU_SRA  = 11'h200;
    localparam logic [10:0] ALU_LUI  = 11'h400;

    // rs1 is taken as signed for every op whose result depends on its sign.
    // MUL is included: the low word is sign-agnostic, so this is harmless.
    function automatic logic md_rs1_signed(input muldiv_op_e op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_rs2_signed(input muldiv_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/alu.sv
// One-hot RV32I ALU.
//   alu_fun : one-hot function select (ALU_* in riscv_pkg); all-zero gives 0
//   op_a    : first operand
//   op_b    : second operand (shift amount in the low bits for shifts)
//   result  : combinational result
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [10:0]     alu_fun,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result
);

    localparam int SW = $clog2(XLEN);

    logic [SW-1:0] shamt;
    assign shamt = op_b[SW-1:0];

    always_comb begin
        result = '0;
        case (alu_fun)
            ALU_ADD:  result = op_a + op_b;
            ALU_SUB:  result = op_a - op_b;
            ALU_SLL:  result = op_a << shamt;
            ALU_SRL:  result = op_a >> shamt;
            ALU_SRA:  result = $unsigned($signed(op_a) >>> shamt);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:  result = op_a ^ op_b;
            ALU_OR:   result = op_a | op_b;
            ALU_AND:  result = op_a & op_b;
            ALU_LUI:  result = op_b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer with fixed latency.
//   clk_i    : rising-edge clock
//   rst_ni   : asynchronous active-low reset
//   start_i  : launch request, sampled in IDLE only
//   kill_i   : synchronous abort; wins over start_i in IDLE
//   op_i     : RV32M funct3
//   rs1_i    : dividend / multiplicand
//   rs2_i    : divisor / multiplier
//   busy_o   : high whenever not IDLE
//   done_o   : one-cycle pulse, result_o valid in that cycle
//   result_o : result register
//
// state  | meaning
// IDLE   | waiting for start_i
// PREP_A | register |rs1| (negate through the ALU when signed and negative)
// PREP_B | register |rs2|, initialise the accumulators
// ITER   | 32 shift-add or restoring shift-subtract steps
// FIX    | apply result sign / select high or low word into result_o
// DONE   | done_o pulse
module muldiv_seq
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREP_A = 3'd1,
        PREP_B = 3'd2,
        ITER   = 3'd3,
        FIX    = 3'd4,
        DONE   = 3'd5
    } state_e;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    muldiv_op_e      op_q;
    muldiv_op_e      op_in;
    logic            sa_q, sb_q;
    logic [XLEN-1:0] a_q, b_q;
    // hi_q/lo_q hold {hi,lo} for multiply and {r,q} for divide.
    logic [XLEN-1:0] hi_q, lo_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      cnt_q;

    logic [10:0]     alu_fun;
    logic [XLEN-1:0] alu_a, alu_b, alu_res;

    logic            launch;
    logic            launch_special;
    logic [XLEN-1:0] special_res;
    logic            is_div_q;
    logic            fix_neg;
    logic            msb_a, msb_b, msb_s;
    logic            mul_carry, div_borrow;
    logic            div_top;
    logic [XLEN-1:0] div_rs;

    alu #(.XLEN(XLEN)) u_alu (
        .alu_fun (alu_fun),
        .op_a    (alu_a),
        .op_b    (alu_b),
        .result  (alu_res)
    );

    assign op_in    = muldiv_op_e'(op_i);
    assign launch   = (state_q == IDLE) && start_i && !kill_i;
    assign is_div_q = op_q[2];

    // Division special cases resolve at launch without iterating.
    always_comb begin
        launch_special = 1'b0;
        special_res    = '0;
        if (op_i[2] && (rs2_i == '0)) begin
            launch_special = 1'b1;
            special_res    = op_i[1] ? rs1_i : '1;
        end else if (((op_in == MD_DIV) || (op_in == MD_REM)) &&
                     (rs1_i == INT_MIN) && (rs2_i == '1)) begin
            launch_special = 1'b1;
            special_res    = op_i[1] ? '0 : INT_MIN;
        end
    end

    always_comb begin
        case (op_q)
            MD_MUL, MD_MULH, MD_DIV: fix_neg = sa_q ^ sb_q;
            MD_MULHSU, MD_REM:       fix_neg = sa_q;
            default:                 fix_neg = 1'b0;
        endcase
    end

    // Carry-out / borrow recovered from operand and result MSBs, so the
    // single ALU adder serves as the 33-bit accumulator.
    assign msb_a      = alu_a[XLEN-1];
    assign msb_b      = alu_b[XLEN-1];
    assign msb_s      = alu_res[XLEN-1];
    assign mul_carry  = (msb_a & msb_b) | ((msb_a ^ msb_b) & ~msb_s);
    assign div_borrow = (~msb_a & msb_b) | (~(msb_a ^ msb_b) & msb_s);
    assign div_top    = hi_q[XLEN-1];
    assign div_rs     = {hi_q[XLEN-2:0], lo_q[XLEN-1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        alu_fun = '0;
        alu_a   = '0;
        alu_b   = '0;
        case (state_q)
            IDLE: begin
                if (launch) state_d = launch_special ? DONE : PREP_A;
            end
            PREP_A: begin
                alu_fun = sa_q ? ALU_SUB : ALU_ADD;
                alu_b   = a_q;
                state_d = PREP_B;
            end
            PREP_B: begin
                alu_fun = sb_q ? ALU_SUB : ALU_ADD;
                alu_b   = b_q;
                state_d = ITER;
            end
            ITER: begin
                if (is_div_q) begin
                    alu_fun = ALU_SUB;
                    alu_a   = div_rs;
                    alu_b   = b_q;
                end else begin
                    alu_fun = ALU_ADD;
                    alu_a   = hi_q;
                    alu_b   = lo_q[0] ? a_q : '0;
                end
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                case (op_q)
                    MD_MUL, MD_DIV, MD_DIVU: begin
                        alu_fun = fix_neg ? ALU_SUB : ALU_ADD;
                        alu_b   = lo_q;
                    end
                    MD_MULH, MD_MULHSU: begin
                        alu_fun = ALU_ADD;
                        if (fix_neg) begin
                            // Two's-complement high word: ~hi plus carry out of -lo.
                            alu_a = ~hi_q;
                            alu_b = {{(XLEN-1){1'b0}}, lo_q == '0};
                        end else begin
                            alu_a = hi_q;
                        end
                    end
                    MD_MULHU: begin
                        alu_fun = ALU_ADD;
                        alu_a   = hi_q;
                    end
                    default: begin
                        alu_fun = fix_neg ? ALU_SUB : ALU_ADD;
                        alu_b   = hi_q;
                    end
                endcase
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= MD_MUL;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        op_q  <= op_in;
                        a_q   <= rs1_i;
                        b_q   <= rs2_i;
                        sa_q  <= md_rs1_signed(op_in) & rs1_i[XLEN-1];
                        sb_q  <= md_rs2_signed(op_in) & rs2_i[XLEN-1];
                        cnt_q <= '0;
                        if (launch_special) result_q <= special_res;
                    end
                end
                PREP_A: a_q <= alu_res;
                PREP_B: begin
                    b_q   <= alu_res;
                    hi_q  <= '0;
                    lo_q  <= is_div_q ? a_q : alu_res;
                    cnt_q <= '0;
                end
                ITER: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (!is_div_q) begin
                        hi_q <= {mul_carry, alu_res[XLEN-1:1]};
                        lo_q <= {alu_res[0], lo_q[XLEN-1:1]};
                    end else if (div_top || !div_borrow) begin
                        hi_q <= alu_res;
                        lo_q <= {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_q <= div_rs;
                        lo_q <= {lo_q[XLEN-2:0], 1'b0};
                    end
                end
                FIX: begin
                    if (!kill_i) result_q <= alu_res;
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE) && !kill_i;
    assign result_o = result_q;

    a_alu_fun_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(alu_fun));

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        kill_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_res;

    always #5 clk_i = ~clk_i;

    muldiv_seq dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .kill_i   (kill_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RV32M semantics straight from 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit ref_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 3'd4 && b == 0) return 1'b1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    // Launches one op and follows it to done_o. poke > 0 drives a stray
    // start with different operands during that busy cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int poke);
        logic [31:0] exp;
        logic [31:0] got;
        int lat_exp;
        int lat;
        exp     = ref_md(op, a, b);
        lat_exp = ref_special(op, a, b) ? 1 : 36;
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
        @(negedge clk_i);
        lat = 0;
        got = 'x;
        for (int c = 1; c <= 40; c++) begin
            start_i = (c == poke);
            op_i    = 3'($urandom_range(0, 7));
            rs1_i   = $urandom;
            rs2_i   = $urandom;
            if (done_o === 1'b1) begin
                lat = c;
                got = result_o;
                break;
            end
            @(negedge clk_i);
        end
        start_i = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "_result"}, got, exp);
        @(negedge clk_i);
        check({tag, "_idle_after"}, {30'b0, busy_o, done_o}, 32'd0);
        last_res = exp;
    endtask

    // ALU function select must be onehot0 always, and zero while idle.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            checks++;
            assert ($onehot0(dut.alu_fun) && (busy_o || dut.alu_fun == 11'd0)) else begin
                failures++;
                $error("FAIL alu_fun observed=%h expected=onehot0 busy=%b", dut.alu_fun, busy_o);
            end
        end
    end

    initial begin
        logic seen;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        rst_ni = 1'b0; start_i = 1'b0; kill_i = 1'b0;
        op_i = 3'd0; rs1_i = '0; rs2_i = '0;
        repeat (2) @(negedge clk_i);
        check("reset_outputs", {busy_o, done_o, 30'b0} | result_o, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("idle_after_reset", {30'b0, busy_o, done_o}, 32'd0);

        run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mul_ff",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mul_m3_7", 3'd0, 32'hFFFF_FFFD, 32'd7, 0);
        run_op("mulh_m3_7", 3'd1, 32'hFFFF_FFFD, 32'd7, 0);
        run_op("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 0);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 0);
        run_op("divu_by0", 3'd5, 32'h1234, 32'd0, 0);
        run_op("rem_by0", 3'd6, 32'h1234, 32'd0, 0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);

        // Stray start while busy must not disturb the running op.
        run_op("divu_poke", 3'd5, 32'hDEAD_BEEF, 32'd1234, 5);
        run_op("mul_poke", 3'd1, 32'h8765_4321, 32'hF00D_0001, 30);

        // Kill mid-operation.
        @(negedge clk_i);
        start_i = 1'b1; op_i = 3'd0; rs1_i = $urandom; rs2_i = $urandom;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        check("kill_busy_low", {31'b0, busy_o}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done_o === 1'b1) seen = 1'b1;
            @(negedge clk_i);
        end
        check("kill_no_done", {31'b0, seen}, 32'd0);
        check("kill_result_kept", result_o, last_res);
        run_op("mul_6_7_after_kill", 3'd0, 32'd6, 32'd7, 0);

        // Kill in IDLE wins over start.
        start_i = 1'b1; kill_i = 1'b1; op_i = 3'd5; rs1_i = 32'd9; rs2_i = 32'd0;
        @(negedge clk_i);
        start_i = 1'b0; kill_i = 1'b0;
        check("idle_kill_priority", {30'b0, busy_o, done_o}, 32'd0);

        // Reset in the middle of an operation.
        @(negedge clk_i);
        start_i = 1'b1; op_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (19) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("midop_reset_outputs", {busy_o, done_o, 30'b0} | result_o, 32'd0);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (done_o === 1'b1 || busy_o === 1'b1) seen = 1'b1;
        end
        check("midop_reset_quiet", {31'b0, seen}, 32'd0);

        // Random ops, with corner operand values mixed in.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 17));
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
